cdm16_alu: RTL and testbench

Combinational 16-bit ALU of the CdM-16 core with a registered CVZN flag latch. It computes address sums, arithmetic, logic, shift/rotate and byte-extension results from operand buses bus0/bus1. Its result drives both the address bus and the ALU→busD path. The core's instruction decoder supplies `op_type`, `func`, the shift count and the carry-select; the flag register mirrors PS[3:0].

---
 rtl/cdm16_pkg.sv | 53 +++++
 rtl/cdm16_alu_if.sv | 24 ++
 rtl/cdm16_shifter.sv | 62 ++++++
 rtl/cdm16_alu.sv | 154 +++++++++++++++
 tb/tb_cdm16_alu.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/cdm16_pkg.sv
// Shared encodings for the CdM-16 ALU slice.
// Operation classes, function codes and CVZN flag layout.
package cdm16_pkg;

    localparam logic [2:0] OP_ADDR  = 3'd0;
    localparam logic [2:0] OP_LOGIC = 3'd1;
    localparam logic [2:0] OP_ARITH = 3'd2;
    localparam logic [2:0] OP_SHIFT = 3'd3;
    localparam logic [2:0] OP_EXT   = 3'd4;

    localparam logic [2:0] F_AND = 3'd0;
    localparam logic [2:0] F_OR  = 3'd1;
    localparam logic [2:0] F_XOR = 3'd2;
    localparam logic [2:0] F_BIC = 3'd3;
    localparam logic [2:0] F_NOT = 3'd4;

    localparam logic [2:0] F_ADD = 3'd0;
    localparam logic [2:0] F_SUB = 3'd1;
    localparam logic [2:0] F_CMP = 3'd2;
    localparam logic [2:0] F_NEG = 3'd3;

    localparam logic [2:0] SH_SHL  = 3'd0;
    localparam logic [2:0] SH_SHR  = 3'd1;
    localparam logic [2:0] SH_SHRA = 3'd2;
    localparam logic [2:0] SH_ROL  = 3'd3;
    localparam logic [2:0] SH_ROR  = 3'd4;

    localparam logic [2:0] X_SXT  = 3'd0;
    localparam logic [2:0] X_ZXT  = 3'd1;
    localparam logic [2:0] X_SWAB = 3'd2;

    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    typedef struct packed {
        logic c;
        logic v;
        logic z;
        logic n;
    } cvzn_t;

    // Two's-complement overflow of x + y (+cin) given the result sign.
    function automatic logic add_ovf(
        input logic [15:0] x,
        input logic [15:0] y,
        input logic [15:0] s
    );
        return (x[15] == y[15]) && (s[15] != x[15]);
    endfunction

endpackage

// File: rtl/cdm16_alu_if.sv
// Operand/result bundle between the CdM-16 decoder and its ALU.
// The decoder side is master; the ALU is slave.
interface cdm16_alu_if;
    logic [15:0] A;
    logic [15:0] B;
    logic        Cin;
    logic [2:0]  op_type;
    logic [2:0]  func;
    logic [2:0]  shif_count_ni;
    logic        flags_we;
    logic [15:0] S;
    logic [3:0]  CVZN;
    logic [3:0]  flags_q;

    modport master (
        output A, B, Cin, op_type, func, shif_count_ni, flags_we,
        input  S, CVZN, flags_q
    );

    modport slave (
        input  A, B, Cin, op_type, func, shif_count_ni, flags_we,
        output S, CVZN, flags_q
    );
endinterface

// File: rtl/cdm16_shifter.sv
// Combinational barrel shift/rotate by 1..8 with carry-out.
// Carry is the last bit shifted or rotated out.
module cdm16_shifter
    import cdm16_pkg::*;
(
    input  logic [15:0] a,
    input  logic [2:0]  func,
    input  logic [2:0]  cnt_ni,
    output logic [15:0] s,
    output logic        c
);

    logic [4:0]  n;
    logic [16:0] shl_t;
    logic [16:0] shr_t;
    logic [16:0] sra_t;
    logic [31:0] rol_t;
    logic [31:0] ror_t;

    assign n = {2'b00, cnt_ni} + 5'd1;

    // Extra bit beside the operand catches the final bit pushed out.
    always_comb begin
        shl_t = {1'b0, a} << n;
        shr_t = {a, 1'b0} >> n;
        sra_t = $signed({a, 1'b0}) >>> n;
        rol_t = {a, a} << n;
        ror_t = {a, a} >> n;
    end

    always_comb begin
        s = a;
        c = 1'b0;
        unique case (1'b1)
            (func == SH_SHL): begin
                s = shl_t[15:0];
                c = shl_t[16];
            end
            (func == SH_SHR): begin
                s = shr_t[16:1];
                c = shr_t[0];
            end
            (func == SH_SHRA): begin
                s = sra_t[16:1];
                c = sra_t[0];
            end
            (func == SH_ROL): begin
                s = rol_t[31:16];
                c = rol_t[16];
            end
            (func == SH_ROR): begin
                s = ror_t[15:0];
                c = ror_t[15];
            end
            default: begin
                s = a;
                c = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/cdm16_alu.sv
// CdM-16 ALU: address/arith/logic/shift/ext datapath.
// CVZN flags latch on the falling clock edge.
module cdm16_alu
    import cdm16_pkg::*;
(
    input  logic         input_clock,
    input  logic         rst_n,
    cdm16_alu_if.slave   bus
);

    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic [2:0]  fn;

    assign a  = bus.A;
    assign b  = bus.B;
    assign op = bus.op_type;
    assign fn = bus.func;

    logic [15:0] add_x;
    logic [15:0] add_y;
    logic        add_c;
    logic [16:0] sum;
    logic        sum_v;

    // SUB/CMP and NEG reuse the adder with inverted operands.
    always_comb begin
        add_x = a;
        add_y = b;
        add_c = bus.Cin;
        if (op == OP_ARITH) begin
            unique case (1'b1)
                (fn == F_SUB),
                (fn == F_CMP): begin
                    add_y = ~b;
                    add_c = ~bus.Cin;
                end
                (fn == F_NEG): begin
                    add_x = 16'h0000;
                    add_y = ~a;
                    add_c = 1'b1;
                end
                default: begin
                    add_y = b;
                end
            endcase
        end
    end

    assign sum   = {1'b0, add_x} + {1'b0, add_y} + {16'h0000, add_c};
    assign sum_v = add_ovf(add_x, add_y, sum[15:0]);

    logic [15:0] logic_s;

    always_comb begin
        logic_s = a;
        unique case (1'b1)
            (fn == F_AND): logic_s = a & b;
            (fn == F_OR):  logic_s = a | b;
            (fn == F_XOR): logic_s = a ^ b;
            (fn == F_BIC): logic_s = a & ~b;
            (fn == F_NOT): logic_s = ~a;
            default:       logic_s = a;
        endcase
    end

    logic [15:0] ext_s;

    always_comb begin
        ext_s = a;
        unique case (1'b1)
            (fn == X_SXT):  ext_s = {{8{a[7]}}, a[7:0]};
            (fn == X_ZXT):  ext_s = {8'h00, a[7:0]};
            (fn == X_SWAB): ext_s = {a[7:0], a[15:8]};
            default:        ext_s = a;
        endcase
    end

    logic [15:0] sh_s;
    logic        sh_c;

    cdm16_shifter u_shifter (
        .a      (a),
        .func   (fn),
        .cnt_ni (bus.shif_count_ni),
        .s      (sh_s),
        .c      (sh_c)
    );

    logic [15:0] res;
    logic        res_c;
    logic        res_v;

    always_comb begin
        res   = a;
        res_c = 1'b0;
        res_v = 1'b0;
        unique case (1'b1)
            (op == OP_ADDR): begin
                res   = sum[15:0];
                res_c = sum[16];
                res_v = sum_v;
            end
            (op == OP_LOGIC): begin
                res = logic_s;
            end
            (op == OP_ARITH): begin
                if (fn <= F_NEG) begin
                    res   = sum[15:0];
                    res_c = sum[16];
                    res_v = sum_v;
                end
            end
            (op == OP_SHIFT): begin
                res   = sh_s;
                res_c = sh_c;
            end
            (op == OP_EXT): begin
                res = ext_s;
            end
            default: begin
                res = a;
            end
        endcase
    end

    cvzn_t flags;

    always_comb begin
        flags   = '0;
        flags.c = res_c;
        flags.v = res_v;
        flags.z = (res == 16'h0000);
        flags.n = res[15];
    end

    assign bus.S    = res;
    assign bus.CVZN = flags;

    logic [3:0] flags_r;

    // Falling edge keeps the latch in step with the register file.
    always_ff @(negedge input_clock or negedge rst_n) begin
        if (!rst_n) begin
            flags_r <= 4'b0000;
        end else if (bus.flags_we) begin
            flags_r <= flags;
        end
    end

    assign bus.flags_q = flags_r;

endmodule

// File: tb/tb_cdm16_alu.sv
// Scoreboard bench for cdm16_alu: directed vectors plus random
// operations against an arithmetic reference model.
module tb_cdm16_alu;

    logic input_clock;
    logic rst_n;

    cdm16_alu_if bus ();

    cdm16_alu dut (
        .input_clock (input_clock),
        .rst_n       (rst_n),
        .bus         (bus)
    );

    initial input_clock = 1'b0;
    always #5 input_clock = ~input_clock;

    typedef struct {
        int          idx;
        logic [15:0] s;
        logic [3:0]  f;
        logic [3:0]  fq;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          vec_idx  = 0;
    logic [3:0]  fq_model = 4'b0000;

    task automatic check(input string nm, input int idx,
                         input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s vec%0d: got %h expected %h", nm, idx, act, req);
    endtask

    function automatic logic ovf(input int x);
        return (x > 32767) || (x < -32768);
    endfunction

    // Reference model from the arithmetic definitions of each operation.
    function automatic void model(
        input  logic [15:0] a, input logic [15:0] b, input logic cin,
        input  logic [2:0] op, input logic [2:0] f, input logic [2:0] cnt,
        output logic [15:0] s, output logic [3:0] fl
    );
        int r, sa, sb_, ci, n, p, ua, ub;
        logic c, v;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb_ = int'($signed(b));
        ci = cin ? 1 : 0;
        s = a; c = 1'b0; v = 1'b0;
        n = int'(cnt) + 1;
        p = 1 << n;
        if (op == 3'd0 || (op == 3'd2 && f == 3'd0)) begin
            r = ua + ub + ci;
            s = r[15:0];
            c = (r > 65535);
            v = ovf(sa + sb_ + ci);
        end else if (op == 3'd1) begin
            case (f)
                3'd0: s = a & b;
                3'd1: s = a | b;
                3'd2: s = a ^ b;
                3'd3: s = a & ~b;
                3'd4: s = ~a;
                default: s = a;
            endcase
        end else if (op == 3'd2) begin
            if (f == 3'd1 || f == 3'd2) begin
                r = ua - ub - ci;
                s = r[15:0];
                c = (ua >= ub + ci);
                v = ovf(sa - sb_ - ci);
            end else if (f == 3'd3) begin
                r = -ua;
                s = r[15:0];
                c = (ua == 0);
                v = ovf(-sa);
            end
        end else if (op == 3'd3) begin
            case (f)
                3'd0: begin r = ua * p; s = r[15:0]; c = r[16]; end
                3'd1: begin r = ua / p; s = r[15:0]; c = ((ua / (p / 2)) % 2) == 1; end
                3'd2: begin r = sa >>> n; s = r[15:0]; c = ((ua / (p / 2)) % 2) == 1; end
                3'd3: begin
                    r = ua * p;
                    r = (r % 65536) + (r / 65536);
                    s = r[15:0];
                    c = s[0];
                end
                3'd4: begin
                    r = ua / p + (ua % p) * (65536 / p);
                    s = r[15:0];
                    c = s[15];
                end
                default: s = a;
            endcase
        end else if (op == 3'd4) begin
            case (f)
                3'd0: begin r = int'($signed(a[7:0])); s = r[15:0]; end
                3'd1: begin r = ua % 256; s = r[15:0]; end
                3'd2: begin r = (ua % 256) * 256 + ua / 256; s = r[15:0]; end
                default: s = a;
            endcase
        end
        fl = {c, v, (s == 16'h0000), s[15]};
    endfunction

    task automatic apply(
        input logic [15:0] a, input logic [15:0] b, input logic cin,
        input logic [2:0] op, input logic [2:0] f, input logic [2:0] cnt,
        input logic we, input logic use_exp,
        input logic [15:0] es, input logic [3:0] ef
    );
        exp_t e;
        logic [15:0] ms;
        logic [3:0]  mf;
        @(negedge input_clock);
        #1;
        bus.A = a; bus.B = b; bus.Cin = cin;
        bus.op_type = op; bus.func = f;
        bus.shif_count_ni = cnt; bus.flags_we = we;
        model(a, b, cin, op, f, cnt, ms, mf);
        if (use_exp) begin
            ms = es;
            mf = ef;
        end
        e.idx = vec_idx; e.s = ms; e.f = mf; e.fq = fq_model;
        sb.push_back(e);
        vec_idx++;
        if (we && rst_n) fq_model = mf;
    endtask

    task automatic rand_vec();
        apply(16'($urandom), 16'($urandom), 1'($urandom),
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              3'($urandom), 1'($urandom), 1'b0, 16'h0, 4'h0);
    endtask

    task automatic assert_reset();
        @(posedge input_clock);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_flags_q", vec_idx, {12'h0, bus.flags_q}, 16'h0000);
        fq_model = 4'b0000;
    endtask

    task automatic release_reset();
        @(negedge input_clock);
        #1;
        bus.flags_we = 1'b0;
        rst_n = 1'b1;
    endtask

    always @(posedge input_clock) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("S", e.idx, bus.S, e.s);
            check("CVZN", e.idx, {12'h0, bus.CVZN}, {12'h0, e.f});
            check("flags_q", e.idx, {12'h0, bus.flags_q}, {12'h0, e.fq});
        end
    end

    initial begin
        int budget;
        rst_n = 1'b0;
        bus.A = '0; bus.B = '0; bus.Cin = 1'b0;
        bus.op_type = '0; bus.func = '0;
        bus.shif_count_ni = '0; bus.flags_we = 1'b1;
        #3;
        check("reset_flags_q", -1, {12'h0, bus.flags_q}, 16'h0000);
        release_reset();

        apply(16'h1234, 16'h0001, 1'b1, 3'd0, 3'd5, 3'd0, 1'b1, 1'b1, 16'h1236, 4'b0000);
        apply(16'h7FFF, 16'h0001, 1'b0, 3'd2, 3'd0, 3'd0, 1'b1, 1'b1, 16'h8000, 4'b0101);
        apply(16'hFFFF, 16'h0001, 1'b0, 3'd2, 3'd0, 3'd0, 1'b1, 1'b1, 16'h0000, 4'b1010);
        apply(16'h0005, 16'h0007, 1'b0, 3'd2, 3'd1, 3'd0, 1'b1, 1'b1, 16'hFFFE, 4'b0001);
        apply(16'h0007, 16'h0005, 1'b0, 3'd2, 3'd1, 3'd0, 1'b0, 1'b1, 16'h0002, 4'b1000);
        apply(16'h8001, 16'h0000, 1'b0, 3'd3, 3'd2, 3'd0, 1'b1, 1'b1, 16'hC000, 4'b1001);
        apply(16'h8001, 16'h0000, 1'b0, 3'd3, 3'd3, 3'd7, 1'b0, 1'b1, 16'h0180, 4'b0000);
        apply(16'h00FF, 16'h0000, 1'b0, 3'd3, 3'd0, 3'd7, 1'b0, 1'b1, 16'hFF00, 4'b0001);
        apply(16'h0001, 16'h0000, 1'b0, 3'd3, 3'd4, 3'd7, 1'b0, 1'b1, 16'h0100, 4'b0000);
        apply(16'h1280, 16'h0000, 1'b0, 3'd4, 3'd0, 3'd0, 1'b0, 1'b1, 16'hFF80, 4'b0001);
        apply(16'h1280, 16'h0000, 1'b0, 3'd4, 3'd1, 3'd0, 1'b0, 1'b1, 16'h0080, 4'b0000);
        apply(16'h1234, 16'h0000, 1'b0, 3'd4, 3'd2, 3'd0, 1'b0, 1'b1, 16'h3412, 4'b0000);
        apply(16'h0001, 16'h0000, 1'b0, 3'd2, 3'd3, 3'd0, 1'b0, 1'b1, 16'hFFFF, 4'b0001);
        apply(16'h8000, 16'h0001, 1'b0, 3'd2, 3'd2, 3'd0, 1'b0, 1'b1, 16'h7FFF, 4'b1100);
        apply(16'h0000, 16'h0000, 1'b0, 3'd2, 3'd3, 3'd0, 1'b0, 1'b1, 16'h0000, 4'b1010);
        apply(16'h1234, 16'h5678, 1'b1, 3'd6, 3'd1, 3'd3, 1'b0, 1'b1, 16'h1234, 4'b0000);
        apply(16'h1234, 16'h0000, 1'b0, 3'd1, 3'd0, 3'd0, 1'b1, 1'b1, 16'h0000, 4'b0010);

        // Latched 0010 must hold while operands keep changing.
        for (int i = 0; i < 6; i++) begin
            apply(16'($urandom), 16'($urandom), 1'($urandom),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom), 1'b0, 1'b0, 16'h0, 4'h0);
        end

        assert_reset();
        apply(16'hFFFF, 16'h0001, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 16'h0, 4'h0);
        apply(16'h8000, 16'h8000, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 16'h0, 4'h0);
        release_reset();

        for (int i = 0; i < 400; i++) begin
            rand_vec();
            if (i % 97 == 50) begin
                assert_reset();
                rand_vec();
                release_reset();
            end
        end

        budget = 0;
        while (sb.size() != 0 && budget < 10) begin
            @(posedge input_clock);
            budget++;
        end
        #1;
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
